// File: rtl/ir_window_ctrl.sv
// Windowed IR pulse-rate controller: synchronizes detect_pin, counts rising edges over
// back-to-back fixed windows and drives a debounced threshold decision on mode.
module ir_window_ctrl #(
   parameter int unsigned WINDOW_CYCLES = 2000,
   parameter int unsigned CNT_W         = 10,
   parameter int unsigned THRESH        = 7,
   parameter int unsigned CONFIRM       = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             detect_pin,
   output logic             mode,
   output logic [CNT_W-1:0] pulse_count,
   output logic             count_valid,
   output logic             busy
);

   localparam int unsigned TMR_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
   localparam int unsigned AGR_W = (CONFIRM > 1) ? $clog2(CONFIRM + 1) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_MEASURE,
      S_EVAL
   } state_t;

   state_t             state_q;
   logic               sync1_q, sync2_q, prev_q;
   logic               edge_flag;
   logic [TMR_W-1:0]   timer_q;
   logic [CNT_W-1:0]   edge_cnt_q;
   logic [AGR_W-1:0]   agree_q;
   logic [AGR_W-1:0]   agree_d;
   logic               mode_q, mode_d;
   logic               vote_d;
   logic [CNT_W-1:0]   pulse_count_q;
   logic               count_valid_q;
   logic               busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= detect_pin;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign edge_flag = sync2_q & ~prev_q;

   // A disagreeing window only flips mode after CONFIRM consecutive votes against it.
   always_comb begin
      vote_d  = (32'(edge_cnt_q) >= THRESH);
      agree_d = '0;
      mode_d  = mode_q;
      if (vote_d != mode_q) begin
         if ((agree_q + AGR_W'(1)) == AGR_W'(CONFIRM)) begin
            mode_d = ~mode_q;
         end else begin
            agree_d = agree_q + AGR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         timer_q       <= '0;
         edge_cnt_q    <= '0;
         agree_q       <= '0;
         mode_q        <= 1'b0;
         pulse_count_q <= '0;
         count_valid_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         count_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (enable) begin
                  state_q <= S_ARM;
                  busy_q  <= 1'b1;
               end
            end
            S_ARM: begin
               edge_cnt_q <= '0;
               timer_q    <= '0;
               agree_q    <= '0;
               state_q    <= S_MEASURE;
            end
            S_MEASURE: begin
               // Losing enable abandons the window; results and agree state are kept.
               if (!enable) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  if (edge_flag && (edge_cnt_q != '1)) begin
                     edge_cnt_q <= edge_cnt_q + CNT_W'(1);
                  end
                  if (timer_q == TMR_LAST) begin
                     state_q <= S_EVAL;
                  end else begin
                     timer_q <= timer_q + TMR_W'(1);
                  end
               end
            end
            S_EVAL: begin
               pulse_count_q <= edge_cnt_q;
               count_valid_q <= 1'b1;
               mode_q        <= mode_d;
               agree_q       <= agree_d;
               edge_cnt_q    <= '0;
               timer_q       <= '0;
               if (enable) begin
                  state_q <= S_MEASURE;
               end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mode        = mode_q;
   assign pulse_count = pulse_count_q;
   assign count_valid = count_valid_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_ir_window_ctrl.sv
// Scoreboard bench for ir_window_ctrl: directed windows push expected results, a negedge
// monitor pops them on each count_valid strobe and checks that outputs hold in between.
module tb_ir_window_ctrl;

   localparam int W = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       detect_pin = 1'b0;
   logic       mode;
   logic [3:0] pulse_count;
   logic       count_valid;
   logic       busy;

   ir_window_ctrl #(
      .WINDOW_CYCLES(W),
      .CNT_W        (4),
      .THRESH       (7),
      .CONFIRM      (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .detect_pin (detect_pin),
      .mode       (mode),
      .pulse_count(pulse_count),
      .count_valid(count_valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [3:0] cnt;
      logic       md;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Outputs may only move on a strobe; each strobe must match the oldest expectation.
   logic       last_mode;
   logic [3:0] last_pc;
   always @(negedge clk) begin
      if (!rst_n) begin
         last_mode = mode;
         last_pc   = pulse_count;
      end else if (count_valid === 1'b1) begin
         check("strobe_expected", 32'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("strobe_cycle", cyc, e.cyc);
            check("pulse_count", pulse_count, e.cnt);
            check("mode", mode, e.md);
         end
         last_mode = mode;
         last_pc   = pulse_count;
      end else begin
         check("mode_hold", mode, last_mode);
         check("count_hold", pulse_count, last_pc);
      end
   end

   // Called just after the edge that starts MEASURE timer 0. A pin rise driven in slot a
   // is seen by the counter in timer slot a+2; slot W is the EVAL cycle.
   task automatic run_window(input int np, input int hi, input int lo, input int extra_a,
                             input int stop_a, input logic [3:0] ec, input logic em);
      exp_t e;
      if (stop_a < 0) begin
         e.cyc = cyc + W + 1;
         e.cnt = ec;
         e.md  = em;
         sb.push_back(e);
      end
      for (int a = 0; a <= W; a++) begin
         if (a == stop_a) break;
         if ((a < np * (hi + lo)) && ((a % (hi + lo)) < hi)) detect_pin = 1'b1;
         else if (a == extra_a) detect_pin = 1'b1;
         else detect_pin = 1'b0;
         if (a == W) check("busy_eval", busy, 1);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_run();
      enable = 1'b1;
      @(posedge clk);
      #1;
      check("busy_arm", busy, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at %0t", $time);
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_mode", mode, 0);
      check("reset_count", pulse_count, 0);
      check("reset_valid", count_valid, 0);
      check("reset_busy", busy, 0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_busy", busy, 0);

      start_run();
      run_window(0, 4, 4, -1, -1, 4'd0, 1'b0);
      run_window(0, 4, 4, -1, -1, 4'd0, 1'b0);
      run_window(10, 4, 4, -1, -1, 4'd10, 1'b0);
      run_window(10, 4, 4, -1, -1, 4'd10, 1'b1);
      run_window(3, 4, 4, -1, -1, 4'd3, 1'b1);
      run_window(9, 4, 4, -1, -1, 4'd9, 1'b1);
      run_window(3, 4, 4, -1, -1, 4'd3, 1'b1);
      run_window(3, 4, 4, -1, -1, 4'd3, 1'b0);
      run_window(20, 2, 2, -1, -1, 4'd15, 1'b0);
      run_window(8, 4, 4, W - 3, -1, 4'd9, 1'b1);
      run_window(0, 4, 4, W - 2, -1, 4'd0, 1'b1);

      run_window(10, 4, 4, -1, 50, 4'd0, 1'b0);
      check("abort_busy_before", busy, 1);
      enable = 1'b0;
      detect_pin = 1'b0;
      @(posedge clk);
      #1;
      check("abort_idle", busy, 0);
      repeat (8) @(posedge clk);
      #1;
      check("abort_count_kept", pulse_count, 0);
      check("abort_mode_kept", mode, 1);
      check("abort_still_idle", busy, 0);

      start_run();
      run_window(0, 4, 4, -1, -1, 4'd0, 1'b1);
      run_window(0, 4, 4, -1, -1, 4'd0, 1'b0);
      run_window(10, 4, 4, -1, -1, 4'd10, 1'b0);
      run_window(10, 4, 4, -1, -1, 4'd10, 1'b1);

      run_window(10, 4, 4, -1, 30, 4'd0, 1'b0);
      #2;
      rst_n = 1'b0;
      detect_pin = 1'b0;
      #1;
      check("async_rst_mode", mode, 0);
      check("async_rst_count", pulse_count, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_valid", count_valid, 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      start_run();
      run_window(10, 4, 4, -1, -1, 4'd10, 1'b0);
      run_window(0, 4, 4, -1, -1, 4'd0, 1'b0);
      run_window(10, 4, 4, -1, -1, 4'd10, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
